imem_fetch_unit: RTL

- Parametrised successor to the single-cycle instruction memory.
- Byte-addressed, big-endian instruction store: instruction at byte address A = {mem[A], mem[A+1]}, widened to INSTR_W.
- Registered read behind a valid/ready request/response handshake, plus a byte-wide program-load port so a boot loader can write code at run time.
- Sits between the PC/fetch stage and the decoder of the multi-cycle/pipelined core.

---
 rtl/imem_fetch_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed big-endian instruction store with registered valid/ready fetch and a byte program-load port.
// Define IMEM_MISALIGN_FETCH_EN to allow misaligned fetches (only out-of-range faults).
module imem_fetch_unit #(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic               rsp_err,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [7:0]         prog_data,
    output logic               prog_err
);
    localparam int BPI = INSTR_W / 8;
    localparam int MAW = $clog2(DEPTH_BYTES);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic               rsp_err_q, rsp_err_d;
    logic               prog_err_q, prog_err_d;
    logic [7:0]         mem_q [DEPTH_BYTES] = '{default: 8'h00};
    logic [ADDR_W:0]    req_end;
    logic [MAW-1:0]     rd_idx;
    logic [INSTR_W-1:0] rd_word;
    logic               oor, mis, fault, accept, prog_oor;
    always_comb begin
        // Range check one bit wider than the address so the last byte never wraps to 0
        req_end  = {1'b0, req_addr} + (ADDR_W+1)'(BPI - 1);
        oor      = req_end >= (ADDR_W+1)'(DEPTH_BYTES);
`ifdef IMEM_MISALIGN_FETCH_EN
        mis      = 1'b0;
`else
        mis      = (req_addr % ADDR_W'(BPI)) != '0;
`endif
        fault    = oor || mis;
        rd_idx   = req_addr[MAW-1:0];
        rd_word  = '0;
        for (int i = 0; i < BPI; i++) rd_word[INSTR_W-1-8*i -: 8] = mem_q[rd_idx + MAW'(i)];
        prog_oor = {1'b0, prog_addr} >= (ADDR_W+1)'(DEPTH_BYTES);
        req_ready   = !prog_we && (state_q == EMPTY || rsp_ready);
        accept      = req_valid && req_ready;
        state_d     = accept ? FULL : (rsp_ready ? EMPTY : state_q);
        rsp_instr_d = accept ? (fault ? '0 : rd_word) : rsp_instr_q;
        rsp_addr_d  = accept ? req_addr : rsp_addr_q;
        rsp_err_d   = accept ? fault : rsp_err_q;
        prog_err_d  = prog_we && prog_oor;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            prog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            prog_err_q  <= prog_err_d;
        end
    end
    // Memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (prog_we && !prog_oor) mem_q[prog_addr[MAW-1:0]] <= prog_data;
    end
    assign rsp_valid = state_q == FULL;
    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;
    assign prog_err  = prog_err_q;
endmodule
